// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: FSM state encoding,
// bus widths and the default identification byte.
package apb_pkg;

  localparam int APB_DATA_W = 8;
  localparam int APB_ADDR_W = 32;

  // Value returned by the read-only top register unless overridden
  localparam logic [APB_DATA_W-1:0] APB_DEFAULT_ID = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter for the APB register slave. Loads a count when a
// transfer enters SETUP and counts down during ACCESS; zero marks the
// cycle the slave may complete. Compiled only when APB_SLV_WAIT_EN is
// defined; without it the slave completes on the first ACCESS cycle.
`ifdef APB_SLV_WAIT_EN
module apb_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  // Load on SETUP entry, otherwise decrement until zero is reached
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule
`endif

// File: rtl/apb_reg_slave.sv
// APB responder serving a window of 8-bit registers. The top register is
// a read-only ID byte; register 0 is exported as a control byte.
// Optional wait states are enabled by defining APB_SLV_WAIT_EN.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_DEFAULT_ID
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  selx,
  input  logic                  enable,
  input  logic                  write,
  input  logic [APB_ADDR_W-1:0] addr,
  input  logic [APB_DATA_W-1:0] w_data,
  output logic [APB_DATA_W-1:0] r_data,
  output logic                  ready,
  output logic                  slverr,
  output logic [APB_DATA_W-1:0] reg0_q
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_REGS - 1);

  apb_state_e state;

  // Transfer attributes latched when SETUP is entered
  logic [IDX_W-1:0]      cap_idx;
  logic                  cap_valid;
  logic                  cap_top;
  logic                  cap_write;
  logic [APB_DATA_W-1:0] cap_wdata;

  logic [APB_DATA_W-1:0] regs [NUM_REGS];

  logic [APB_ADDR_W-1:0] offset;
  logic                  hit;
  logic [IDX_W-1:0]      idx_now;
  logic                  cnt_zero;
  logic                  setup_go;
  logic                  xfer_err;
  logic                  commit;

  // Unsigned offset wraps for addresses below the window, so a single
  // compare covers both bounds; all-ones is excluded so a window placed at
  // the top of the map can never claim it.
  assign offset  = addr - BASE_ADDR;
  assign hit     = (offset < APB_ADDR_W'(NUM_REGS)) && (addr != '1);
  assign idx_now = offset[IDX_W-1:0];

  // Dropping selx during ACCESS is an abort, so completion also needs selx
  assign ready    = (state == ACCESS) && selx && cnt_zero;
  assign setup_go = selx && !enable && ((state == IDLE) || ready);

  assign xfer_err = !cap_valid || (cap_write && cap_top);
  assign slverr   = ready && xfer_err;
  assign commit   = ready && cap_write && !xfer_err;

  assign reg0_q = regs[0];

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  apb_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (setup_go),
    .dec      (state == ACCESS),
    .load_val (WAIT_LD),
    .zero     (cnt_zero)
  );
`else
  logic unused_wait;

  assign cnt_zero    = 1'b1;
  assign unused_wait = (WAIT_CYCLES != 0);
`endif

  // Transfer sequencing: IDLE -> SETUP -> ACCESS, with abort on selx drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (setup_go) state <= SETUP;
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (!selx) begin
            state <= IDLE;
          end else if (ready) begin
            state <= setup_go ? SETUP : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Latch decoded address, direction and write data on SETUP entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_idx   <= '0;
      cap_valid <= 1'b0;
      cap_top   <= 1'b0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else if (setup_go) begin
      cap_idx   <= idx_now;
      cap_valid <= hit;
      cap_top   <= hit && (idx_now == TOP_IDX);
      cap_write <= write;
      cap_wdata <= w_data;
    end
  end

  // Read data is fetched during the SETUP cycle of a read and then held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if ((state == SETUP) && !cap_write) begin
      if (!cap_valid) begin
        r_data <= '0;
      end else if (cap_top) begin
        r_data <= ID_VALUE;
      end else begin
        r_data <= regs[cap_idx];
      end
    end
  end

  // Register bank: a write lands on the completing ACCESS edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[cap_idx] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: directed scenarios plus random
// transfers compared against an array-based model of the register window.
module tb_apb_reg_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          NREG  = 16;
  localparam int          WAITS = 2;
  localparam logic [7:0]  IDV   = 8'hA5;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_LAT = WAITS;
`else
  localparam int EXP_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        selx;
  logic        enable;
  logic        write;
  logic [31:0] addr;
  logic [7:0]  w_data;
  logic [7:0]  r_data;
  logic        ready;
  logic        slverr;
  logic [7:0]  reg0_q;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [NREG];
  logic [7:0] m_rdata;
  bit         chained;

  always #5 clk = ~clk;

  apb_reg_slave #(
    .BASE_ADDR   (BASE),
    .NUM_REGS    (NREG),
    .WAIT_CYCLES (WAITS),
    .ID_VALUE    (IDV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .selx   (selx),
    .enable (enable),
    .write  (write),
    .addr   (addr),
    .w_data (w_data),
    .r_data (r_data),
    .ready  (ready),
    .slverr (slverr),
    .reg0_q (reg0_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (a != 32'hFFFF_FFFF) && (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(NREG));
  endfunction

  // One complete transfer; with chain=1 the next transfer's SETUP is
  // presented in this transfer's ready cycle (back-to-back).
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit chain, input string tag);
    int k;
    bit ok;
    bit top;
    int idx;
    if (!chained) @(negedge clk);
    selx = 1'b1; enable = 1'b0; write = wr; addr = a; w_data = d;
    @(negedge clk);
    // access phase: scramble address/data/direction, they must be ignored
    enable = 1'b1; addr = $urandom; w_data = 8'($urandom); write = ~wr;
    k = 0;
    @(negedge clk);
    while (!ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    ok  = in_window(a);
    idx = ok ? int'(a - BASE) : 0;
    top = ok && (idx == NREG - 1);
    if (!wr) m_rdata = !ok ? 8'h00 : (top ? IDV : mem[idx]);
    check({tag, ".lat"}, 32'(k), 32'(EXP_LAT));
    check({tag, ".err"}, 32'(slverr), 32'(!ok || (wr && top)));
    check({tag, ".rd"},  32'(r_data), 32'(m_rdata));
    check({tag, ".r0"},  32'(reg0_q), 32'(mem[0]));
    if (ok && wr && !top) mem[idx] = d;
    if (chain) begin
      enable  = 1'b0;
      chained = 1'b1;
    end else begin
      chained = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; selx = 1'b0; enable = 1'b0; write = 1'b0;
    addr = '0; w_data = '0; chained = 1'b0; m_rdata = 8'h00;
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;

    // reset values
    repeat (3) @(negedge clk);
    check("rst0.rdata",  32'(r_data), 32'h0);
    check("rst0.ready",  32'(ready),  32'h0);
    check("rst0.slverr", 32'(slverr), 32'h0);
    check("rst0.reg0",   32'(reg0_q), 32'h0);
    reset = 1'b1;

    // load some state so the asynchronous clear is visible
    xfer(1'b1, BASE, 8'h77, 1'b0, "pre_w0");
    xfer(1'b0, BASE + 32'd15, 8'h00, 1'b0, "pre_id");

    // reset asserted during ACCESS of a write of 3C to register 0
    @(negedge clk);
    selx = 1'b1; enable = 1'b0; write = 1'b1; addr = BASE; w_data = 8'h3C;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst.rdata",  32'(r_data), 32'h0);
    check("midrst.ready",  32'(ready),  32'h0);
    check("midrst.slverr", 32'(slverr), 32'h0);
    check("midrst.reg0",   32'(reg0_q), 32'h0);
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
    m_rdata = 8'h00;
    @(negedge clk);
    selx = 1'b0; enable = 1'b0; reset = 1'b1; chained = 1'b0;
    xfer(1'b0, BASE, 8'h00, 1'b0, "rst_rd0");

    // write then read back register 1
    xfer(1'b1, BASE + 32'd1, 8'h5A, 1'b0, "w5a");
    xfer(1'b0, BASE + 32'd1, 8'h00, 1'b0, "r5a");

    // ID register: readable, write rejected
    xfer(1'b0, BASE + 32'd15, 8'h00, 1'b0, "rid");
    xfer(1'b1, BASE + 32'd15, 8'hFF, 1'b0, "wid");
    xfer(1'b0, BASE + 32'd15, 8'h00, 1'b0, "rid2");

    // out-of-window accesses
    xfer(1'b0, BASE + 32'd16, 8'h00, 1'b0, "roob_hi");
    xfer(1'b0, 32'h0000_0000, 8'h00, 1'b0, "roob_0");
    xfer(1'b1, 32'hFFFF_FFFF, 8'h11, 1'b0, "woob_ff");

    // enable without a setup phase is ignored
    xfer(1'b1, BASE + 32'd3, 8'h33, 1'b0, "w3");
    @(negedge clk);
    selx = 1'b1; enable = 1'b1; write = 1'b1; addr = BASE + 32'd3; w_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("noset.ready", 32'(ready), 32'h0);
    end
    selx = 1'b0; enable = 1'b0;
    xfer(1'b0, BASE + 32'd3, 8'h00, 1'b0, "noset.rd");

    // selx dropped during ACCESS aborts the write
    xfer(1'b1, BASE + 32'd2, 8'h22, 1'b0, "w2");
    @(negedge clk);
    selx = 1'b1; enable = 1'b0; write = 1'b1; addr = BASE + 32'd2; w_data = 8'hAA;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    selx = 1'b0;
    #1;
    check("abort.ready", 32'(ready), 32'h0);
    @(negedge clk);
    check("abort.idle", 32'(ready), 32'h0);
    enable = 1'b0;
    xfer(1'b0, BASE + 32'd2, 8'h00, 1'b0, "abort.rd");

    // register 0 output follows one cycle after the ready cycle
    xfer(1'b1, BASE, 8'h81, 1'b0, "w81");
    @(negedge clk);
    check("w81.reg0", 32'(reg0_q), 32'h81);

    // back-to-back write/read pairs
    xfer(1'b1, BASE + 32'd4, 8'hC4, 1'b1, "b2b.w");
    xfer(1'b0, BASE + 32'd4, 8'h00, 1'b1, "b2b.r");
    xfer(1'b1, BASE + 32'd5, 8'h5C, 1'b1, "b2b.w2");
    xfer(1'b0, BASE + 32'd5, 8'h00, 1'b0, "b2b.r2");

    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'hFFFF_FFFF;
      else               a = BASE - 32'd2 + 32'($urandom_range(0, 19));
      xfer(1'($urandom_range(0, 1)), a, 8'($urandom), (n != 59) && ($urandom_range(0, 1) == 1), "rnd");
    end

    // final sweep of the whole window
    for (int i = 0; i < NREG; i++) begin
      xfer(1'b0, BASE + 32'(i), 8'h00, 1'b0, "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

- APB responder: a bank of 8-bit registers, addressed by a 32-bit APB address, serving the bus master's read and write transfers.
- Sits on the shared APB bus beside the master and decodes its own address window.
- Inserts a fixed number of wait states and flags an error on bad accesses.
- Drives register 0 out to the surrounding logic as a control byte.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_1000, first byte address of the register window.
- NUM_REGS, 16, number of 8-bit registers; legal range 2..256.
- WAIT_CYCLES, 2, wait states inserted per transfer when APB_SLV_WAIT_EN is defined; legal range 0..15.
- ID_VALUE, 8'hA5, constant returned by the top register (index NUM_REGS-1), which is read-only.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  reset, asynchronous and active-low; all state clears while low.
- selx  input  1  slave select from the master.
- enable  input  1  access-phase strobe.
- write  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- w_data  input  8  write data.
- r_data  output  8  read data; registered.
- ready  output  1  transfer completes in this cycle.
- slverr  output  1  error response; valid only while ready=1.
- reg0_q  output  8  live value of register 0.

## Operation
- FSM states:
  - IDLE: stays in IDLE unless selx=1 and enable=0; then goes to SETUP.
  - SETUP: always goes to ACCESS on the next cycle.
  - ACCESS: held until ready=1. When ready=1, goes to SETUP if selx=1 and enable=0, else to IDLE.
- Address decode:
  - In range when BASE_ADDR <= addr < BASE_ADDR+NUM_REGS.
  - Index = (addr-BASE_ADDR), truncated to $clog2(NUM_REGS) bits; the subtraction is 32-bit.
- Capture on SETUP entry: addr, write and w_data. Later changes to these inputs during ACCESS have no effect.
- Read data:
  - r_data loads in the SETUP cycle: the register value, or ID_VALUE for the top index, or 8'h00 if out of range.
  - r_data holds until the next SETUP; write transfers do not change it.
- Write commit:
  - Happens on the ACCESS cycle with ready=1, only when the index is valid, writable and slverr=0.
  - A write to the top register is dropped and sets slverr=1.
- slverr=1 for an out-of-range address (read or write) or a write to the ID register. It is 0 at all other times.
- Protocol errors:
  - enable=1 while in IDLE, with no SETUP before it, is ignored: ready stays 0 and nothing is written.
  - selx=0 while in ACCESS aborts the transfer: next state is IDLE, no write, ready=0.
- Reset low, mid-transfer:
  - Forces IDLE and clears all registers; the interrupted write is lost.
  - Outputs take reset values immediately (asynchronous).

## Timing
- Reset values: r_data=8'h00, ready=0, slverr=0, reg0_q=8'h00, all registers 8'h00, FSM in IDLE, wait counter 0.
- Cycle T0 is SETUP; the first ACCESS cycle is T1.
- ready is combinational: (state==ACCESS) && (wait count==0).
- Wait counter loads WAIT_CYCLES on SETUP entry and decrements each ACCESS cycle until it reaches 0.
- ready=1 at T1+WAIT_CYCLES; the write lands in the register on that edge.
- reg0_q reflects a write to register 0 one cycle after the ready cycle.
- Back-to-back transfers: new SETUP in the cycle after ready=1. Minimum is 2 cycles per transfer with 0 wait states.
- Address 0xFFFF_FFFF never matches a valid register, for any BASE_ADDR; it gives slverr and no write.

## Configuration
- Macro: APB_SLV_WAIT_EN.
- Defined: the wait counter is instantiated; ready asserts WAIT_CYCLES cycles into ACCESS.
- Undefined: counter removed, WAIT_CYCLES ignored; ready=1 on the first ACCESS cycle, every transfer takes 2 cycles.
- Data, error and decode behaviour are the same in both builds.

## Structure
- Package apb_pkg holds:
  - the FSM enum (IDLE, SETUP, ACCESS);
  - APB_DATA_W=8 and APB_ADDR_W=32;
  - the default ID constant.
- Sub-module apb_wait_counter (4-bit load/decrement, zero flag), compiled only under APB_SLV_WAIT_EN.
- Top holds the FSM, decode, register array and output muxing.

## Test plan
- Reset low mid-ACCESS of a write 8'h3C to BASE_ADDR -> outputs 0 at once; register 0 reads back 8'h00 after reset is released.
- Write 8'h5A to BASE_ADDR+1, then read it back, WAIT_CYCLES=2 with macro defined:
  - ready high at T3 for each transfer;
  - r_data=8'h5A;
  - slverr=0.
- Same write/read sequence with macro undefined -> ready at T1, same data.
- Read BASE_ADDR+15 -> 8'hA5, slverr=0.
- Write 8'hFF to BASE_ADDR+15 -> slverr=1; readback is still 8'hA5.
- Read BASE_ADDR+16, then 0x0000_0000 -> slverr=1 and r_data=8'h00 for both.
- Protocol errors:
  - enable=1 from IDLE with no setup -> ready stays 0 for 5 cycles.
  - selx dropped in ACCESS -> FSM returns to IDLE and the target register is unchanged.
- Write 8'h81 to register 0 -> reg0_q=8'h81 one cycle after ready.
